// File: rtl/tl_buffer_if.sv
// TileLink channel bundle (A-E) shared by hosts, devices and buffers.
// The host modport drives A, C and E and accepts B and D; the device modport is the mirror image.
interface tl_channel #(
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3
);
    localparam int MaskWidth = (DataWidth >= 8) ? DataWidth / 8 : 1;

    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_param;
    logic [SizeWidth-1:0]   a_size;
    logic [SourceWidth-1:0] a_source;
    logic [AddrWidth-1:0]   a_address;
    logic [MaskWidth-1:0]   a_mask;
    logic [DataWidth-1:0]   a_data;
    logic                   a_corrupt;

    logic                   b_valid;
    logic                   b_ready;
    logic [2:0]             b_opcode;
    logic [1:0]             b_param;
    logic [SizeWidth-1:0]   b_size;
    logic [SourceWidth-1:0] b_source;
    logic [AddrWidth-1:0]   b_address;
    logic [MaskWidth-1:0]   b_mask;
    logic [DataWidth-1:0]   b_data;
    logic                   b_corrupt;

    logic                   c_valid;
    logic                   c_ready;
    logic [2:0]             c_opcode;
    logic [2:0]             c_param;
    logic [SizeWidth-1:0]   c_size;
    logic [SourceWidth-1:0] c_source;
    logic [AddrWidth-1:0]   c_address;
    logic [DataWidth-1:0]   c_data;
    logic                   c_corrupt;

    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [1:0]             d_param;
    logic [SizeWidth-1:0]   d_size;
    logic [SourceWidth-1:0] d_source;
    logic [SinkWidth-1:0]   d_sink;
    logic                   d_denied;
    logic [DataWidth-1:0]   d_data;
    logic                   d_corrupt;

    logic                   e_valid;
    logic                   e_ready;
    logic [SinkWidth-1:0]   e_sink;

    modport host (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );

    modport device (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );

endinterface

// File: rtl/tl_buffer.sv
// TileLink buffer: one independent register-based FIFO per channel (A-E), depth 0 = wire.
// Ready depends only on the fill level and output payload only on storage, so no comb paths cross a buffered channel.
module tl_buffer_fifo #(
    parameter int Width      = 1,
    parameter int Depth      = 2,
    parameter int LevelWidth = (Depth > 0) ? $clog2(Depth + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Width-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Width-1:0]      out_data,
    output logic [LevelWidth-1:0] level
);

    if (Depth <= 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign level     = '0;
    end else begin : g_fifo
        localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
        // Array spans the full pointer range so indexing is width-exact; slots at or above Depth are never written.
        localparam int MemDepth = 2 ** PtrWidth;
        localparam logic [PtrWidth-1:0]   LastPtr = PtrWidth'(Depth - 1);
        localparam logic [LevelWidth-1:0] Full    = LevelWidth'(Depth);

        logic [Width-1:0]      mem [MemDepth];
        logic [PtrWidth-1:0]   wptr;
        logic [PtrWidth-1:0]   rptr;
        logic [LevelWidth-1:0] count;
        logic                  push;
        logic                  pop;

        assign in_ready  = (count != Full);
        assign out_valid = (count != '0);
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        assign out_data  = mem[rptr];
        assign level     = count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= in_data;
            end
        end
    end

endmodule

module tl_buffer #(
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3,
    parameter int ADepth      = 2,
    parameter int BDepth      = 2,
    parameter int CDepth      = 2,
    parameter int DDepth      = 2,
    parameter int EDepth      = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    tl_channel.device host,
    tl_channel.host   device,
    output logic [((ADepth > 0) ? $clog2(ADepth + 1) : 1) - 1:0] a_level_o,
    output logic [((BDepth > 0) ? $clog2(BDepth + 1) : 1) - 1:0] b_level_o,
    output logic [((CDepth > 0) ? $clog2(CDepth + 1) : 1) - 1:0] c_level_o,
    output logic [((DDepth > 0) ? $clog2(DDepth + 1) : 1) - 1:0] d_level_o,
    output logic [((EDepth > 0) ? $clog2(EDepth + 1) : 1) - 1:0] e_level_o
);

    localparam int MaskWidth = (DataWidth >= 8) ? DataWidth / 8 : 1;
    localparam int AWidth = 3 + 3 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + DataWidth + 1;
    localparam int BWidth = 3 + 2 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + DataWidth + 1;
    localparam int CWidth = 3 + 3 + SizeWidth + SourceWidth + AddrWidth + DataWidth + 1;
    localparam int DWidth = 3 + 2 + SizeWidth + SourceWidth + SinkWidth + 1 + DataWidth + 1;
    localparam int EWidth = SinkWidth;

    if (ADepth < 0 || BDepth < 0 || CDepth < 0 || DDepth < 0 || EDepth < 0) begin : g_bad_depth
        $fatal(1, "tl_buffer: channel depths must be non-negative");
    end
    if (DataWidth < 1 || (DataWidth & (DataWidth - 1)) != 0) begin : g_bad_width
        $fatal(1, "tl_buffer: DataWidth must be a power of 2");
    end

    logic [AWidth-1:0] a_in, a_out;
    logic [BWidth-1:0] b_in, b_out;
    logic [CWidth-1:0] c_in, c_out;
    logic [DWidth-1:0] d_in, d_out;
    logic [EWidth-1:0] e_in, e_out;

    assign a_in = {host.a_opcode, host.a_param, host.a_size, host.a_source, host.a_address,
                   host.a_mask, host.a_data, host.a_corrupt};
    assign {device.a_opcode, device.a_param, device.a_size, device.a_source, device.a_address,
            device.a_mask, device.a_data, device.a_corrupt} = a_out;

    assign b_in = {device.b_opcode, device.b_param, device.b_size, device.b_source, device.b_address,
                   device.b_mask, device.b_data, device.b_corrupt};
    assign {host.b_opcode, host.b_param, host.b_size, host.b_source, host.b_address,
            host.b_mask, host.b_data, host.b_corrupt} = b_out;

    assign c_in = {host.c_opcode, host.c_param, host.c_size, host.c_source, host.c_address,
                   host.c_data, host.c_corrupt};
    assign {device.c_opcode, device.c_param, device.c_size, device.c_source, device.c_address,
            device.c_data, device.c_corrupt} = c_out;

    assign d_in = {device.d_opcode, device.d_param, device.d_size, device.d_source, device.d_sink,
                   device.d_denied, device.d_data, device.d_corrupt};
    assign {host.d_opcode, host.d_param, host.d_size, host.d_source, host.d_sink,
            host.d_denied, host.d_data, host.d_corrupt} = d_out;

    assign e_in = host.e_sink;
    assign device.e_sink = e_out;

    tl_buffer_fifo #(.Width(AWidth), .Depth(ADepth)) a_fifo (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(host.a_valid), .in_ready(host.a_ready), .in_data(a_in),
        .out_valid(device.a_valid), .out_ready(device.a_ready), .out_data(a_out),
        .level(a_level_o)
    );

    tl_buffer_fifo #(.Width(BWidth), .Depth(BDepth)) b_fifo (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(device.b_valid), .in_ready(device.b_ready), .in_data(b_in),
        .out_valid(host.b_valid), .out_ready(host.b_ready), .out_data(b_out),
        .level(b_level_o)
    );

    tl_buffer_fifo #(.Width(CWidth), .Depth(CDepth)) c_fifo (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(host.c_valid), .in_ready(host.c_ready), .in_data(c_in),
        .out_valid(device.c_valid), .out_ready(device.c_ready), .out_data(c_out),
        .level(c_level_o)
    );

    tl_buffer_fifo #(.Width(DWidth), .Depth(DDepth)) d_fifo (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(device.d_valid), .in_ready(device.d_ready), .in_data(d_in),
        .out_valid(host.d_valid), .out_ready(host.d_ready), .out_data(d_out),
        .level(d_level_o)
    );

    tl_buffer_fifo #(.Width(EWidth), .Depth(EDepth)) e_fifo (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(host.e_valid), .in_ready(host.e_ready), .in_data(e_in),
        .out_valid(device.e_valid), .out_ready(device.e_ready), .out_data(e_out),
        .level(e_level_o)
    );

endmodule

// File: tb/tb_tl_buffer.sv
// Randomised bench for tl_buffer with A=2, B=2, C=1, D=3, E=0 entries.
// Each channel is checked against a queue holding the beats that should be buffered.
module tb_tl_buffer;

    localparam int SW = 8;
    localparam int KW = 4;
    localparam int AW = 56;
    localparam int DW = 64;
    localparam int ZW = 3;
    localparam int MW = DW / 8;

    typedef struct packed {
        logic [2:0] opcode; logic [2:0] param; logic [ZW-1:0] size; logic [SW-1:0] source;
        logic [AW-1:0] address; logic [MW-1:0] mask; logic [DW-1:0] data; logic corrupt;
    } a_beat_t;
    typedef struct packed {
        logic [2:0] opcode; logic [1:0] param; logic [ZW-1:0] size; logic [SW-1:0] source;
        logic [AW-1:0] address; logic [MW-1:0] mask; logic [DW-1:0] data; logic corrupt;
    } b_beat_t;
    typedef struct packed {
        logic [2:0] opcode; logic [2:0] param; logic [ZW-1:0] size; logic [SW-1:0] source;
        logic [AW-1:0] address; logic [DW-1:0] data; logic corrupt;
    } c_beat_t;
    typedef struct packed {
        logic [2:0] opcode; logic [1:0] param; logic [ZW-1:0] size; logic [SW-1:0] source;
        logic [KW-1:0] sink; logic denied; logic [DW-1:0] data; logic corrupt;
    } d_beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] a_level, b_level, d_level;
    logic [0:0] c_level, e_level;
    int errors = 0;
    int checks = 0;

    tl_channel #(.SourceWidth(SW), .SinkWidth(KW), .AddrWidth(AW), .DataWidth(DW), .SizeWidth(ZW)) host_bus ();
    tl_channel #(.SourceWidth(SW), .SinkWidth(KW), .AddrWidth(AW), .DataWidth(DW), .SizeWidth(ZW)) dev_bus ();

    tl_buffer #(
        .SourceWidth(SW), .SinkWidth(KW), .AddrWidth(AW), .DataWidth(DW), .SizeWidth(ZW),
        .ADepth(2), .BDepth(2), .CDepth(1), .DDepth(3), .EDepth(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host(host_bus), .device(dev_bus),
        .a_level_o(a_level), .b_level_o(b_level), .c_level_o(c_level),
        .d_level_o(d_level), .e_level_o(e_level)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic a_beat_t rand_a();
        a_beat_t b;
        b.opcode = 3'($urandom); b.param = 3'($urandom); b.size = ZW'($urandom);
        b.source = SW'($urandom); b.address = AW'(rnd64()); b.mask = MW'($urandom);
        b.data = rnd64(); b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic b_beat_t rand_b();
        b_beat_t b;
        b.opcode = 3'($urandom); b.param = 2'($urandom); b.size = ZW'($urandom);
        b.source = SW'($urandom); b.address = AW'(rnd64()); b.mask = MW'($urandom);
        b.data = rnd64(); b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic c_beat_t rand_c();
        c_beat_t b;
        b.opcode = 3'($urandom); b.param = 3'($urandom); b.size = ZW'($urandom);
        b.source = SW'($urandom); b.address = AW'(rnd64()); b.data = rnd64();
        b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic d_beat_t rand_d();
        d_beat_t b;
        b.opcode = 3'($urandom); b.param = 2'($urandom); b.size = ZW'($urandom);
        b.source = SW'($urandom); b.sink = KW'($urandom); b.denied = 1'($urandom);
        b.data = rnd64(); b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic a_beat_t get_a();
        a_beat_t b;
        b.opcode = dev_bus.a_opcode; b.param = dev_bus.a_param; b.size = dev_bus.a_size;
        b.source = dev_bus.a_source; b.address = dev_bus.a_address; b.mask = dev_bus.a_mask;
        b.data = dev_bus.a_data; b.corrupt = dev_bus.a_corrupt;
        return b;
    endfunction

    function automatic b_beat_t get_b();
        b_beat_t b;
        b.opcode = host_bus.b_opcode; b.param = host_bus.b_param; b.size = host_bus.b_size;
        b.source = host_bus.b_source; b.address = host_bus.b_address; b.mask = host_bus.b_mask;
        b.data = host_bus.b_data; b.corrupt = host_bus.b_corrupt;
        return b;
    endfunction

    function automatic c_beat_t get_c();
        c_beat_t b;
        b.opcode = dev_bus.c_opcode; b.param = dev_bus.c_param; b.size = dev_bus.c_size;
        b.source = dev_bus.c_source; b.address = dev_bus.c_address; b.data = dev_bus.c_data;
        b.corrupt = dev_bus.c_corrupt;
        return b;
    endfunction

    function automatic d_beat_t get_d();
        d_beat_t b;
        b.opcode = host_bus.d_opcode; b.param = host_bus.d_param; b.size = host_bus.d_size;
        b.source = host_bus.d_source; b.sink = host_bus.d_sink; b.denied = host_bus.d_denied;
        b.data = host_bus.d_data; b.corrupt = host_bus.d_corrupt;
        return b;
    endfunction

    task automatic drive_a(input a_beat_t b);
        host_bus.a_opcode = b.opcode; host_bus.a_param = b.param; host_bus.a_size = b.size;
        host_bus.a_source = b.source; host_bus.a_address = b.address; host_bus.a_mask = b.mask;
        host_bus.a_data = b.data; host_bus.a_corrupt = b.corrupt;
    endtask

    task automatic drive_b(input b_beat_t b);
        dev_bus.b_opcode = b.opcode; dev_bus.b_param = b.param; dev_bus.b_size = b.size;
        dev_bus.b_source = b.source; dev_bus.b_address = b.address; dev_bus.b_mask = b.mask;
        dev_bus.b_data = b.data; dev_bus.b_corrupt = b.corrupt;
    endtask

    task automatic drive_c(input c_beat_t b);
        host_bus.c_opcode = b.opcode; host_bus.c_param = b.param; host_bus.c_size = b.size;
        host_bus.c_source = b.source; host_bus.c_address = b.address; host_bus.c_data = b.data;
        host_bus.c_corrupt = b.corrupt;
    endtask

    task automatic drive_d(input d_beat_t b);
        dev_bus.d_opcode = b.opcode; dev_bus.d_param = b.param; dev_bus.d_size = b.size;
        dev_bus.d_source = b.source; dev_bus.d_sink = b.sink; dev_bus.d_denied = b.denied;
        dev_bus.d_data = b.data; dev_bus.d_corrupt = b.corrupt;
    endtask

    task automatic idle_all();
        drive_a('0); drive_b('0); drive_c('0); drive_d('0);
        host_bus.a_valid = 1'b0; host_bus.c_valid = 1'b0; host_bus.e_valid = 1'b0;
        host_bus.e_sink = '0; host_bus.b_ready = 1'b0; host_bus.d_ready = 1'b0;
        dev_bus.b_valid = 1'b0; dev_bus.d_valid = 1'b0;
        dev_bus.a_ready = 1'b0; dev_bus.c_ready = 1'b0; dev_bus.e_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({dev_bus.a_valid, host_bus.b_valid, dev_bus.c_valid, host_bus.d_valid, dev_bus.e_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 00000", {dev_bus.a_valid, host_bus.b_valid, dev_bus.c_valid, host_bus.d_valid, dev_bus.e_valid});
        end
        checks++; if ({host_bus.a_ready, dev_bus.b_ready, host_bus.c_ready, dev_bus.d_ready} !== 4'b1111) begin
            errors++; $display("FAIL reset_readys: got %b want 1111", {host_bus.a_ready, dev_bus.b_ready, host_bus.c_ready, dev_bus.d_ready});
        end
        checks++; if ({a_level, b_level, c_level, d_level, e_level} !== 8'b0) begin
            errors++; $display("FAIL reset_levels: got %b want 0", {a_level, b_level, c_level, d_level, e_level});
        end
        // one beat into A, then an asynchronous reset between clock edges
        @(posedge clk); #1; drive_a(rand_a()); host_bus.a_valid = 1'b1;
        @(posedge clk); #1; host_bus.a_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_level !== 2'd1 || dev_bus.a_valid !== 1'b1) begin
            errors++; $display("FAIL prereset_a: got level=%0d valid=%b want level=1 valid=1", a_level, dev_bus.a_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dev_bus.a_valid !== 1'b0 || a_level !== 2'd0 || host_bus.a_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_a: got valid=%b level=%0d ready=%b want 0 0 1", dev_bus.a_valid, a_level, host_bus.a_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_a_burst();
        a_beat_t sent[8];
        int drops = 0;
        @(posedge clk); #1; idle_all(); dev_bus.a_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k < 8) begin
                sent[k] = rand_a(); sent[k].address = AW'(k * 8);
                drive_a(sent[k]); host_bus.a_valid = 1'b1;
            end else begin
                host_bus.a_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8 && host_bus.a_ready !== 1'b1) drops++;
            checks++; if (dev_bus.a_valid !== (k >= 1 && k <= 8)) begin
                errors++; $display("FAIL a_burst_valid[%0d]: got %b want %b", k, dev_bus.a_valid, (k >= 1 && k <= 8));
            end
            checks++; if (a_level !== ((k >= 1 && k <= 8) ? 2'd1 : 2'd0)) begin
                errors++; $display("FAIL a_burst_level[%0d]: got %0d want %0d", k, a_level, (k >= 1 && k <= 8) ? 1 : 0);
            end
            if (k >= 1 && k <= 8) begin
                checks++; if (get_a() !== sent[k-1]) begin
                    errors++; $display("FAIL a_burst_beat[%0d]: got %h want %h", k - 1, get_a(), sent[k-1]);
                end
            end
        end
        checks++; if (drops !== 0) begin
            errors++; $display("FAIL a_burst_ready: ready dropped %0d times, want 0", drops);
        end
    endtask

    task automatic test_a_backpressure();
        a_beat_t beats[3];
        a_beat_t q[$];
        int idx = 0;
        int pops = 0;
        int third_cyc = -1;
        bit exp_push, exp_pop;
        @(posedge clk); #1; idle_all();
        for (int i = 0; i < 3; i++) beats[i] = rand_a();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc == 5) dev_bus.a_ready = 1'b1;
            if (idx < 3) begin drive_a(beats[idx]); host_bus.a_valid = 1'b1; end
            else host_bus.a_valid = 1'b0;
            @(negedge clk);
            checks++; if (host_bus.a_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL a_bp_ready[%0d]: got %b want %b", cyc, host_bus.a_ready, (q.size() < 2));
            end
            checks++; if (a_level !== 2'(q.size())) begin
                errors++; $display("FAIL a_bp_level[%0d]: got %0d want %0d", cyc, a_level, q.size());
            end
            checks++; if (dev_bus.a_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL a_bp_valid[%0d]: got %b want %b", cyc, dev_bus.a_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                checks++; if (get_a() !== q[0]) begin
                    errors++; $display("FAIL a_bp_beat[%0d]: got %h want %h", cyc, get_a(), q[0]);
                end
            end
            exp_push = host_bus.a_valid && (q.size() < 2);
            exp_pop  = (q.size() != 0) && dev_bus.a_ready;
            if (dev_bus.a_valid && dev_bus.a_ready) pops++;
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(beats[idx]);
            if (host_bus.a_valid && host_bus.a_ready) begin
                if (idx == 2) third_cyc = cyc;
                idx++;
            end
        end
        host_bus.a_valid = 1'b0;
        checks++; if (third_cyc !== 6) begin
            errors++; $display("FAIL a_bp_third_accept: got cycle %0d want 6", third_cyc);
        end
        checks++; if (pops !== 3) begin
            errors++; $display("FAIL a_bp_drained: got %0d beats want 3", pops);
        end
    endtask

    task automatic test_c_depth1();
        c_beat_t q[$];
        c_beat_t cur;
        bit offering = 0;
        int pushes = 0;
        int pops = 0;
        bit exp_push, exp_pop;
        @(posedge clk); #1; idle_all(); dev_bus.c_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (!offering) begin cur = rand_c(); offering = 1; end
            drive_c(cur); host_bus.c_valid = 1'b1;
            @(negedge clk);
            checks++; if (host_bus.c_ready !== (q.size() == 0)) begin
                errors++; $display("FAIL c_ready[%0d]: got %b want %b", cyc, host_bus.c_ready, (q.size() == 0));
            end
            checks++; if (dev_bus.c_valid !== (q.size() != 0) || c_level !== 1'(q.size())) begin
                errors++; $display("FAIL c_valid_level[%0d]: got %b/%0d want %b/%0d", cyc, dev_bus.c_valid, c_level, (q.size() != 0), q.size());
            end
            if (q.size() != 0) begin
                checks++; if (get_c() !== q[0]) begin
                    errors++; $display("FAIL c_beat[%0d]: got %h want %h", cyc, get_c(), q[0]);
                end
            end
            exp_pop  = q.size() != 0;
            exp_push = q.size() == 0;
            if (dev_bus.c_valid && dev_bus.c_ready) pops++;
            if (host_bus.c_valid && host_bus.c_ready) begin pushes++; offering = 0; end
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(cur);
        end
        host_bus.c_valid = 1'b0;
        checks++; if (pushes !== 10 || pops !== 10) begin
            errors++; $display("FAIL c_throughput: got push=%0d pop=%0d in 20 cycles want 10/10", pushes, pops);
        end
    endtask

    task automatic test_d_random();
        d_beat_t q[$];
        d_beat_t cur;
        bit offering = 0;
        int sent = 0;
        int got = 0;
        int seen = 0;
        bit exp_push, exp_pop;
        @(posedge clk); #1; idle_all();
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (!offering && sent < 1000 && $urandom_range(0, 1) == 1) begin
                cur = rand_d(); cur.source = SW'(sent); cur.data = DW'(sent);
                offering = 1;
            end
            if (offering) drive_d(cur);
            dev_bus.d_valid = offering;
            host_bus.d_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (dev_bus.d_ready !== (q.size() < 3)) begin
                errors++; $display("FAIL d_ready[%0d]: got %b want %b", cyc, dev_bus.d_ready, (q.size() < 3));
            end
            checks++; if (host_bus.d_valid !== (q.size() != 0) || d_level !== 2'(q.size())) begin
                errors++; $display("FAIL d_valid_level[%0d]: got %b/%0d want %b/%0d", cyc, host_bus.d_valid, d_level, (q.size() != 0), q.size());
            end
            if (q.size() != 0) begin
                checks++; if (get_d() !== q[0]) begin
                    errors++; $display("FAIL d_beat[%0d]: got %h want %h", cyc, get_d(), q[0]);
                end
            end
            exp_push = offering && (q.size() < 3);
            exp_pop  = (q.size() != 0) && host_bus.d_ready;
            if (host_bus.d_valid && host_bus.d_ready) seen++;
            if (exp_pop) begin void'(q.pop_front()); got++; end
            if (exp_push) q.push_back(cur);
            if (offering && dev_bus.d_ready) begin offering = 0; sent++; end
        end
        dev_bus.d_valid = 1'b0; host_bus.d_ready = 1'b0;
        checks++; if (seen !== 1000) begin
            errors++; $display("FAIL d_count: got %0d beats delivered want 1000", seen);
        end
    endtask

    task automatic test_b_random();
        b_beat_t q[$];
        b_beat_t cur;
        bit offering = 0;
        int got = 0;
        int seen = 0;
        bit exp_push, exp_pop;
        @(posedge clk); #1; idle_all();
        for (int cyc = 0; cyc < 5000 && got < 200; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (!offering && $urandom_range(0, 3) != 0) begin cur = rand_b(); offering = 1; end
            if (offering) drive_b(cur);
            dev_bus.b_valid = offering;
            host_bus.b_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++; if (dev_bus.b_ready !== (q.size() < 2) || b_level !== 2'(q.size())) begin
                errors++; $display("FAIL b_ready_level[%0d]: got %b/%0d want %b/%0d", cyc, dev_bus.b_ready, b_level, (q.size() < 2), q.size());
            end
            checks++; if (host_bus.b_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL b_valid[%0d]: got %b want %b", cyc, host_bus.b_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                checks++; if (get_b() !== q[0]) begin
                    errors++; $display("FAIL b_beat[%0d]: got %h want %h", cyc, get_b(), q[0]);
                end
            end
            exp_push = offering && (q.size() < 2);
            exp_pop  = (q.size() != 0) && host_bus.b_ready;
            if (host_bus.b_valid && host_bus.b_ready) seen++;
            if (exp_pop) begin void'(q.pop_front()); got++; end
            if (exp_push) q.push_back(cur);
            if (offering && dev_bus.b_ready) offering = 0;
        end
        dev_bus.b_valid = 1'b0; host_bus.b_ready = 1'b0;
        checks++; if (seen !== 200) begin
            errors++; $display("FAIL b_count: got %0d beats delivered want 200", seen);
        end
    endtask

    task automatic test_e_passthrough();
        logic [KW-1:0] sink;
        logic rdy;
        @(posedge clk); #1; idle_all();
        for (int i = 0; i < 4; i++) begin
            sink = (i == 0) ? KW'(1) : KW'($urandom);
            rdy = 1'(i);
            host_bus.e_valid = 1'b1; host_bus.e_sink = sink; dev_bus.e_ready = rdy;
            #1;
            checks++; if (dev_bus.e_valid !== 1'b1 || dev_bus.e_sink !== sink) begin
                errors++; $display("FAIL e_forward[%0d]: got valid=%b sink=%h want 1/%h", i, dev_bus.e_valid, dev_bus.e_sink, sink);
            end
            checks++; if (host_bus.e_ready !== rdy) begin
                errors++; $display("FAIL e_ready[%0d]: got %b want %b", i, host_bus.e_ready, rdy);
            end
            checks++; if (e_level !== 1'b0) begin
                errors++; $display("FAIL e_level[%0d]: got %0d want 0", i, e_level);
            end
            @(posedge clk); #1;
        end
        host_bus.e_valid = 1'b0;
        #1;
        checks++; if (dev_bus.e_valid !== 1'b0) begin
            errors++; $display("FAIL e_idle: got %b want 0", dev_bus.e_valid);
        end
    endtask

    initial begin
        test_reset();
        test_a_burst();
        test_a_backpressure();
        test_c_depth1();
        test_d_random();
        test_b_random();
        test_e_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
